branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Sequences the execute-stage branch comparator, which registers its result one clock after its operands are presented.
- Accepts one control-flow op (BRANCH/JAL/JALR) at a time from issue via valid/ready. Holds the comparator operands stable, waits the comparator latency, then samples the taken result.
- Computes the target, checks it against the front-end prediction, and emits a one-cycle resolve/redirect pulse to fetch plus a link writeback value.
- Keeps a saturating mispredict counter.

Parameters:
- CMP_LATENCY, 1, clocks from comparator operands valid to comparator taken valid; legal range 1..4.
- CNT_W, 16, width of the mispredict counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- kill  in  1  abort in-flight op (older exception or flush); highest priority
- in_valid  in  1  op offered
- in_ready  out  1  controller can accept
- in_pc  in  32  PC of op
- in_instr  in  32  raw instruction
- in_rs1  in  32  rs1 value
- in_rs2  in  32  rs2 value
- in_pred_taken  in  1  front-end predicted taken
- in_pred_target  in  32  front-end predicted target
- cmp_rs1  out  32  operand to comparator
- cmp_rs2  out  32  operand to comparator
- cmp_instr  out  32  instruction to comparator (funct3 source)
- cmp_taken  in  1  registered comparator result
- res_valid  out  1  one-cycle resolve pulse
- res_taken  out  1  actual direction
- res_redirect  out  1  mispredict; fetch must restart at res_pc
- res_pc  out  32  correct next PC
- res_misaligned  out  1  taken target has bit1 set
- res_illegal  out  1  opcode not BRANCH/JAL/JALR
- link_valid  out  1  JAL/JALR rd writeback
- link_data  out  32  in_pc+4
- mispredict_cnt  out  CNT_W  saturating count of res_redirect pulses

Behaviour:
- FSM states: IDLE, WAIT, EVAL.
  - in_ready = (state==IDLE) && !kill.
- Accept happens on an edge where in_valid && in_ready. At that edge, latch pc, instr, rs1, rs2, pred_taken, pred_target; go to WAIT with wcnt=CMP_LATENCY-1.
- cmp_rs1/cmp_rs2/cmp_instr always drive the latched registers. They change only on accept.
- WAIT: decrement wcnt each cycle; at wcnt==0 go to EVAL. WAIT therefore lasts CMP_LATENCY cycles.
- EVAL: sample cmp_taken; go to IDLE at the next edge. Result registers load at that same edge.
- Latency: accept in cycle t → res_valid high in cycle t+CMP_LATENCY+2. in_ready high again in that same cycle (back-to-back accept allowed). Throughput is one op per CMP_LATENCY+2 cycles.
- Opcode handling (instr[6:0]):
  - BRANCH 1100011: taken=cmp_taken; target=pc+sext(B-imm).
  - JAL 1101111: taken=1; target=pc+sext(J-imm).
  - JALR 1100111: taken=1; target=(rs1+sext(I-imm)) & ~1.
  - Any other opcode: res_illegal=1, taken=0, no redirect, no link, counter unchanged.
- All adds are modulo 2^32 (wrap-around, no trap).
- Misalignment: if taken && target[1]==1, then res_misaligned=1, res_redirect=0, res_taken=1, res_pc=target, counter unchanged.
- Redirect rule (when not illegal and not misaligned):
  - res_pc = taken ? target : pc+4.
  - res_redirect = (taken != pred_taken) || (taken && target != pred_target).
- link_valid=1 with link_data=pc+4 for JAL/JALR only. It is a pulse coincident with res_valid.
- All res_*/link_* outputs are registered and are 0 in every cycle where res_valid==0.
- mispredict_cnt: increments at the edge that asserts res_redirect. It saturates at all-ones.
- kill:
  - In any state, kill at an edge → state IDLE, no result pulse is produced for the in-flight op, and wcnt is cleared.
  - kill in the same cycle as in_valid → not accepted.
  - kill during the res_valid cycle does not retract that pulse.
- reset: state IDLE, wcnt 0, latched regs 0, all res_*/link_* 0, mispredict_cnt 0. in_ready is 0 during reset and 1 in the first cycle after reset deasserts.

Test Plan:
- BEQ (funct3 000), rs1=rs2=5, pc=0x100, B-imm=+16, pred_taken=0, L=1: accept at t → res_valid at t+3, taken=1, redirect=1, res_pc=0x110, mispredict_cnt=1.
- BLTU, rs1=0xFFFFFFFF, rs2=1, pc=0x200, pred_taken=0: taken=0, redirect=0, res_pc=0x204, counter unchanged. The same operands with BLT give taken=1.
- JALR, rs1=0x1003, imm=+4, pc=0x300, pred_target=0x1006, pred_taken=1: target=0x1006, redirect=0, link_valid=1, link_data=0x304.
- JAL with target bit1 set (pc=0x400, J-imm=+2): res_misaligned=1, redirect=0, counter unchanged.
- Opcode 0110011 (ALU op): res_illegal=1, res_taken=0, no redirect, no link.
- kill asserted in WAIT with CMP_LATENCY=3: no res_valid ever appears for that op. The next op is accepted the following cycle and resolves at its own t+5.
- Back-to-back ops with in_valid held high: the second accept coincides with the first res_valid.
- Force 2^CNT_W+2 mispredicts: mispredict_cnt holds at all-ones.
- Reset mid-WAIT: all outputs 0, mispredict_cnt 0, in_ready 1 the cycle after reset deasserts.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage control-flow resolver. Holds operands for a registered
// comparator, waits out its latency, then resolves the op: target, direction,
// mispredict redirect, link writeback and a saturating mispredict counter.
module branch_resolve_ctrl #(
  parameter int unsigned CMP_LATENCY = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             kill,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic             in_pred_taken,
  input  logic [31:0]      in_pred_target,
  output logic [31:0]      cmp_rs1,
  output logic [31:0]      cmp_rs2,
  output logic [31:0]      cmp_instr,
  input  logic             cmp_taken,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_redirect,
  output logic [31:0]      res_pc,
  output logic             res_misaligned,
  output logic             res_illegal,
  output logic             link_valid,
  output logic [31:0]      link_data,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [1:0] WcntInit = 2'(CMP_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StEval} state_e;

  state_e            state_q, state_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic              accept, eval_fire;

  logic [31:0]       pc_q, instr_q, rs1_q, rs2_q, pred_target_q;
  logic              pred_taken_q;

  logic [6:0]        opcode;
  logic              is_branch, is_jal, is_jalr, is_illegal;
  logic [31:0]       imm_b, imm_j, imm_i, target, pc_plus4, next_pc;
  logic              taken, misaligned, redirect, link;

  logic              res_valid_q, res_taken_q, res_redirect_q, res_misaligned_q;
  logic              res_illegal_q, link_valid_q;
  logic [31:0]       res_pc_q, link_data_q;
  logic [CNT_W-1:0]  cnt_q;

  // Reset is folded in so issue never sees a ready while reset is held.
  assign in_ready  = (state_q == StIdle) && !kill && !reset;
  assign accept    = in_valid && in_ready;
  assign eval_fire = (state_q == StEval) && !kill;

  assign cmp_rs1   = rs1_q;
  assign cmp_rs2   = rs2_q;
  assign cmp_instr = instr_q;

  // Next-state: IDLE -> WAIT for CMP_LATENCY cycles -> EVAL -> IDLE; kill wins.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWait;
          wcnt_d  = WcntInit;
        end
      end
      StWait: begin
        if (wcnt_q == 2'd0) state_d = StEval;
        else                wcnt_d  = wcnt_q - 2'd1;
      end
      StEval:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (kill) begin
      state_d = StIdle;
      wcnt_d  = 2'd0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      wcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Operand capture; these stay frozen so the comparator sees stable inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= '0;
      instr_q       <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else if (accept) begin
      pc_q          <= in_pc;
      instr_q       <= in_instr;
      rs1_q         <= in_rs1;
      rs2_q         <= in_rs2;
      pred_taken_q  <= in_pred_taken;
      pred_target_q <= in_pred_target;
    end
  end

  // Decode, target generation and mispredict detection on the latched op.
  always_comb begin
    opcode     = instr_q[6:0];
    is_branch  = (opcode == OpBranch);
    is_jal     = (opcode == OpJal);
    is_jalr    = (opcode == OpJalr);
    is_illegal = !(is_branch || is_jal || is_jalr);
    imm_b      = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                  instr_q[11:8], 1'b0};
    imm_j      = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                  instr_q[30:21], 1'b0};
    imm_i      = {{20{instr_q[31]}}, instr_q[31:20]};
    pc_plus4   = pc_q + 32'd4;
    target     = '0;
    taken      = 1'b0;
    if (is_branch) begin
      target = pc_q + imm_b;
      taken  = cmp_taken;
    end else if (is_jal) begin
      target = pc_q + imm_j;
      taken  = 1'b1;
    end else if (is_jalr) begin
      target = (rs1_q + imm_i) & ~32'd1;
      taken  = 1'b1;
    end
    misaligned = taken && target[1];
    redirect   = !is_illegal && !misaligned &&
                 ((taken != pred_taken_q) || (taken && (target != pred_target_q)));
    next_pc    = taken ? target : pc_plus4;
    link       = is_jal || is_jalr;
  end

  // Result registers: loaded for exactly one cycle out of EVAL, zero otherwise.
  always_ff @(posedge clk) begin
    if (reset || !eval_fire) begin
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_redirect_q   <= 1'b0;
      res_pc_q         <= '0;
      res_misaligned_q <= 1'b0;
      res_illegal_q    <= 1'b0;
      link_valid_q     <= 1'b0;
      link_data_q      <= '0;
    end else begin
      res_valid_q      <= 1'b1;
      res_taken_q      <= taken;
      res_redirect_q   <= redirect;
      res_pc_q         <= next_pc;
      res_misaligned_q <= misaligned;
      res_illegal_q    <= is_illegal;
      link_valid_q     <= link;
      link_data_q      <= link ? pc_plus4 : '0;
    end
  end

  // Saturating mispredict counter, bumped on the edge that raises res_redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (eval_fire && redirect && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign res_valid      = res_valid_q;
  assign res_taken      = res_taken_q;
  assign res_redirect   = res_redirect_q;
  assign res_pc         = res_pc_q;
  assign res_misaligned = res_misaligned_q;
  assign res_illegal    = res_illegal_q;
  assign link_valid     = link_valid_q;
  assign link_data      = link_data_q;
  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl. Instance A (latency 1, 4-bit counter) is
// checked by a scoreboard; instance B (latency 3) gets directed kill sequences.
module tb_branch_resolve_ctrl;

  localparam int unsigned CntW = 4;
  localparam int unsigned CntMax = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Shared op inputs
  logic [31:0] in_pc, in_instr, in_rs1, in_rs2, in_pred_target;
  logic        in_pred_taken;

  // Instance A signals
  logic kill_a, in_valid_a, in_ready_a, cmp_taken_a;
  logic [31:0] cmp_rs1_a, cmp_rs2_a, cmp_instr_a, res_pc_a, link_data_a;
  logic res_valid_a, res_taken_a, res_redirect_a, res_misaligned_a, res_illegal_a;
  logic link_valid_a;
  logic [CntW-1:0] cnt_a;

  // Instance B signals
  logic kill_b, in_valid_b, in_ready_b, cmp_taken_b, cmp_p1_b, cmp_p2_b;
  logic [31:0] cmp_rs1_b, cmp_rs2_b, cmp_instr_b, res_pc_b, link_data_b;
  logic res_valid_b, res_taken_b, res_redirect_b, res_misaligned_b, res_illegal_b;
  logic link_valid_b;
  logic [15:0] cnt_b;

  branch_resolve_ctrl #(.CMP_LATENCY(1), .CNT_W(CntW)) u_dut_a (
    .clk(clk), .reset(reset), .kill(kill_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_pc(in_pc), .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .cmp_rs1(cmp_rs1_a), .cmp_rs2(cmp_rs2_a), .cmp_instr(cmp_instr_a),
    .cmp_taken(cmp_taken_a), .res_valid(res_valid_a), .res_taken(res_taken_a),
    .res_redirect(res_redirect_a), .res_pc(res_pc_a), .res_misaligned(res_misaligned_a),
    .res_illegal(res_illegal_a), .link_valid(link_valid_a), .link_data(link_data_a),
    .mispredict_cnt(cnt_a)
  );

  branch_resolve_ctrl #(.CMP_LATENCY(3), .CNT_W(16)) u_dut_b (
    .clk(clk), .reset(reset), .kill(kill_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_pc(in_pc), .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .cmp_rs1(cmp_rs1_b), .cmp_rs2(cmp_rs2_b), .cmp_instr(cmp_instr_b),
    .cmp_taken(cmp_taken_b), .res_valid(res_valid_b), .res_taken(res_taken_b),
    .res_redirect(res_redirect_b), .res_pc(res_pc_b), .res_misaligned(res_misaligned_b),
    .res_illegal(res_illegal_b), .link_valid(link_valid_b), .link_data(link_data_b),
    .mispredict_cnt(cnt_b)
  );

  function automatic logic cmp_fn(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Comparator models: A registers once, B is a three-deep pipeline.
  always @(posedge clk) cmp_taken_a <= cmp_fn(cmp_instr_a[14:12], cmp_rs1_a, cmp_rs2_a);
  always @(posedge clk) begin
    cmp_p1_b    <= cmp_fn(cmp_instr_b[14:12], cmp_rs1_b, cmp_rs2_b);
    cmp_p2_b    <= cmp_p1_b;
    cmp_taken_b <= cmp_p2_b;
  end

  // kind: 0 branch, 1 jal, 2 jalr, other = ALU op (illegal here)
  function automatic logic [31:0] enc(input int kind, input logic [2:0] f3, input int imm);
    logic [31:0] v;
    v = imm;
    case (kind)
      0:       return {v[12], v[10:5], 5'd2, 5'd1, f3, v[4:1], v[11], 7'b1100011};
      1:       return {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'b1101111};
      2:       return {v[11:0], 5'd1, 3'b000, 5'd1, 7'b1100111};
      default: return {17'h0, f3, 5'd1, 7'b0110011};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic        taken, redirect, misal, illegal, link_valid;
    logic [31:0] pc, link_data;
    bit          chk_pc, chk_link;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  exp_t push_e;
  exp_t mon_e;
  int   cnt_model = 0;

  // Push expectation on the accept edge of instance A.
  always @(posedge clk) begin
    if (reset) begin
      sb.delete();
      cnt_model = 0;
    end else if (in_valid_a && in_ready_a) begin
      push_e     = pend;
      push_e.cyc = cyc + 3;
      sb.push_back(push_e);
    end
  end

  // Pop and compare on result pulses; otherwise outputs must read zero.
  always @(negedge clk) begin
    if (!reset) begin
      if (res_valid_a) begin
        if (sb.size() == 0) begin
          check("unexpected_res_valid", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.redirect && cnt_model < CntMax) cnt_model++;
          check("res_cycle", cyc, mon_e.cyc);
          check("res_taken", res_taken_a, mon_e.taken);
          check("res_redirect", res_redirect_a, mon_e.redirect);
          check("res_misaligned", res_misaligned_a, mon_e.misal);
          check("res_illegal", res_illegal_a, mon_e.illegal);
          if (mon_e.chk_pc) check("res_pc", res_pc_a, mon_e.pc);
          if (mon_e.chk_link) begin
            check("link_valid", link_valid_a, mon_e.link_valid);
            check("link_data", link_data_a, mon_e.link_data);
          end
          check("mispredict_cnt", cnt_a, cnt_model);
        end
      end else begin
        check("idle_outputs_zero", {res_taken_a, res_redirect_a, res_misaligned_a,
              res_illegal_a, link_valid_a, res_pc_a | link_data_a}, 0);
        if (sb.size() > 0 && cyc > sb[0].cyc) begin
          check("res_timeout", cyc, sb[0].cyc);
          mon_e = sb.pop_front();
        end
      end
    end
  end

  // Offer one op to instance A; returns the cycle in which it was accepted.
  task automatic send_a(input int kind, input logic [2:0] f3, input int imm,
                        input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic pt, input logic [31:0] ptgt, output int acc_cyc);
    exp_t        e;
    logic [31:0] tgt;
    logic        tk;
    int          n;
    logic        acc;
    tgt = 32'h0;
    tk  = 1'b0;
    case (kind)
      0: begin tk = cmp_fn(f3, rs1, rs2); tgt = pc + 32'(imm); end
      1: begin tk = 1'b1; tgt = pc + 32'(imm); end
      2: begin tk = 1'b1; tgt = (rs1 + 32'(imm)) & ~32'd1; end
      default: ;
    endcase
    e.illegal    = !(kind == 0 || kind == 1 || kind == 2);
    e.taken      = tk;
    e.misal      = tk && tgt[1];
    e.redirect   = !e.illegal && !e.misal && ((tk != pt) || (tk && tgt != ptgt));
    e.pc         = tk ? tgt : pc + 32'd4;
    e.link_valid = (kind == 1 || kind == 2);
    e.link_data  = e.link_valid ? pc + 32'd4 : 32'h0;
    e.chk_pc     = !e.illegal;
    e.chk_link   = !e.misal;
    e.cyc        = 0;
    pend           = e;
    in_pc          = pc;
    in_instr       = enc(kind, f3, imm);
    in_rs1         = rs1;
    in_rs2         = rs2;
    in_pred_taken  = pt;
    in_pred_target = ptgt;
    in_valid_a     = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("accept_timeout", 0, 1);
    in_valid_a = 1'b0;
    acc_cyc    = cyc - 1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  f3_tab  [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [31:0] val_tab [4] = '{32'hFFFF_FFFF, 32'h1, 32'h8000_0000, 32'h7};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t1, t2, kind, imm;
    logic [31:0] pc;
    logic pt;
    reset = 1'b1;
    kill_a = 1'b0; kill_b = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
    in_pc = '0; in_instr = '0; in_rs1 = '0; in_rs2 = '0;
    in_pred_taken = 1'b0; in_pred_target = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_during_reset", in_ready_a, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", in_ready_a, 1);
    check("cnt_after_reset", cnt_a, 0);
    check("res_valid_after_reset", res_valid_a, 0);
    @(posedge clk);
    #1;

    // BEQ taken, predicted not-taken
    send_a(0, 3'd0, 16, 32'h100, 32'd5, 32'd5, 1'b0, 32'h0, t1);
    drain();
    check("cnt_after_beq", cnt_a, 1);
    // BLTU vs BLT on the same operands
    send_a(0, 3'd6, 32, 32'h200, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, t1);
    send_a(0, 3'd4, 32, 32'h200, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, t1);
    // JALR correctly predicted, JAL misaligned, ALU op illegal
    send_a(2, 3'd0, 4, 32'h300, 32'h1003, 32'h0, 1'b1, 32'h1006, t1);
    send_a(1, 3'd0, 2, 32'h400, 32'h0, 32'h0, 1'b0, 32'h0, t1);
    send_a(3, 3'd0, 0, 32'h500, 32'h3, 32'h4, 1'b1, 32'h40, t1);
    drain();
    check("cnt_after_directed", cnt_a, 2);

    // Back-to-back: second accept lands in the first op's result cycle
    send_a(0, 3'd1, -8, 32'h600, 32'd1, 32'd2, 1'b1, 32'h5F8, t1);
    send_a(0, 3'd7, 12, 32'h700, 32'd3, 32'd9, 1'b0, 32'h0, t2);
    check("b2b_accept_cycle", t2, t1 + 3);
    drain();

    // Random mix
    for (int i = 0; i < 24; i++) begin
      kind = int'($urandom_range(0, 3));
      pc   = 32'h1000 + 32'(4 * $urandom_range(0, 255));
      case (kind)
        0:       imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
        1:       imm = (int'($urandom_range(0, 2047)) - 1024) * 2;
        default: imm = int'($urandom_range(0, 4095)) - 2048;
      endcase
      pt = 1'($urandom_range(0, 1));
      send_a(kind, f3_tab[$urandom_range(0, 5)], imm, pc, val_tab[$urandom_range(0, 3)],
             val_tab[$urandom_range(0, 3)], pt,
             ($urandom_range(0, 1) == 1) ? pc + 32'(imm) : 32'h0ABC, t1);
    end
    drain();

    // Saturation of the 4-bit mispredict counter
    for (int i = 0; i < 18; i++) begin
      send_a(0, 3'd0, 8, 32'h800, 32'd4, 32'd4, 1'b0, 32'h0, t1);
    end
    drain();
    check("cnt_saturated", cnt_a, CntMax);

    // Instance B: kill during WAIT drops the op; the next op resolves at t+5
    in_pc = 32'h500; in_instr = enc(0, 3'd0, 8); in_rs1 = 32'd7; in_rs2 = 32'd7;
    in_pred_taken = 1'b0; in_pred_target = 32'h0;
    in_valid_b = 1'b1;
    @(negedge clk);
    check("b_ready_idle", in_ready_b, 1);
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    t1 = cyc - 1;
    kill_b = 1'b1;
    @(negedge clk);
    check("b_ready_during_kill", in_ready_b, 0);
    @(posedge clk);
    #1;
    kill_b = 1'b0;
    in_pc = 32'h600; in_instr = enc(0, 3'd1, -8); in_rs1 = 32'd1; in_rs2 = 32'd2;
    in_pred_taken = 1'b1; in_pred_target = 32'h5F8;
    in_valid_b = 1'b1;
    @(negedge clk);
    check("b_ready_after_kill", in_ready_b, 1);
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    t2 = cyc - 1;
    check("b_accept_after_kill", t2, t1 + 2);
    for (int i = 0; i < 8; i++) begin
      // Kill in the result cycle must not retract the pulse
      kill_b = (cyc == t2 + 5);
      @(negedge clk);
      check("b_res_valid", res_valid_b, (cyc == t2 + 5));
      if (cyc == t2 + 5) begin
        check("b_res_pc", res_pc_b, 32'h5F8);
        check("b_res_taken", res_taken_b, 1);
        check("b_res_redirect", res_redirect_b, 0);
        check("b_link_valid", link_valid_b, 0);
      end
      @(posedge clk);
      #1;
    end
    kill_b = 1'b0;
    // Kill in the same cycle as in_valid: not accepted, no result
    in_pc = 32'h900; in_instr = enc(0, 3'd0, 8); in_rs1 = 32'd1; in_rs2 = 32'd1;
    in_pred_taken = 1'b0;
    in_valid_b = 1'b1;
    kill_b     = 1'b1;
    @(negedge clk);
    check("b_ready_kill_with_valid", in_ready_b, 0);
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    kill_b     = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("b_no_res_after_kill", res_valid_b, 0);
    end
    @(posedge clk);
    #1;

    // Reset while instance A is in WAIT
    send_a(0, 3'd0, 16, 32'hA00, 32'd2, 32'd2, 1'b0, 32'h0, t1);
    reset = 1'b1;
    @(negedge clk);
    check("ready_in_mid_reset", in_ready_a, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready_a, 1);
    check("rst_res_valid", res_valid_a, 0);
    check("rst_cnt", cnt_a, 0);
    check("rst_cmp_rs1", cmp_rs1_a, 0);
    check("rst_cmp_instr", cmp_instr_a, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_no_res", res_valid_a, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
